// File: rtl/prog_loader_pkg.sv
// ---------------------------------------------------------------------------
// prog_loader_pkg
// Shared definitions for the UART program loader: loader and receiver state
// encodings, the default frame start marker, frame length and write-address
// width.
// ---------------------------------------------------------------------------
package prog_loader_pkg;

  // Frame start marker used unless the top-level parameter overrides it.
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // One frame carries one byte for every CPU instruction address.
  localparam int FRAME_LEN = 32;
  localparam int ADDR_W    = 5;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

  // Depth of the rx_i metastability synchronizer.
  localparam int SYNC_STAGES = 2;

  // Framing FSM owned by prog_loader.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2,
    ST_RUN   = 2'd3
  } loader_state_t;

  // Bit-level FSM owned by uart_rx.
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/prog_loader_uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// 8N1 UART byte receiver, LSB first, idle high. Synchronizes rx_i, detects
// the start edge, rejects glitches shorter than half a bit, samples each data
// bit mid-period and checks the stop bit.
//
// Ports
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   rx_i         asynchronous serial input
//   data_o[7:0]  last received byte (valid while valid_o is high)
//   valid_o      one-cycle pulse: data_o holds a correctly framed byte
//   frame_err_o  one-cycle pulse: stop bit was sampled low, byte discarded
// ---------------------------------------------------------------------------
module uart_rx
  import prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  // Synchronizer chain; stage 0 is the only flop that sees the raw pin.
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic                   rx_sync;
  logic                   fall;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_reg[0] <= 1'b1;
    end else begin
      sync_reg[0] <= rx_i;
    end
  end

  generate
    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          sync_reg[gi] <= 1'b1;
        end else begin
          sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_reg <= 1'b1;
    end else begin
      prev_reg <= rx_sync;
    end
  end

  assign rx_sync = sync_reg[SYNC_STAGES-1];
  assign fall    = prev_reg & ~rx_sync;

  rx_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       bit_reg, bit_next;
  logic [7:0]       shift_reg, shift_next;
  logic [7:0]       data_reg, data_next;
  logic             valid_reg, valid_next;
  logic             ferr_reg, ferr_next;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= RX_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      ferr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      ferr_reg  <= ferr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    data_next  = data_reg;
    valid_next = 1'b0;
    ferr_next  = 1'b0;

    unique case (state_reg)
      RX_IDLE: begin
        if (fall) begin
          // The detection cycle itself counts, so the start bit is re-sampled
          // exactly CLKS_PER_BIT/2 cycles after the edge was seen.
          state_next = RX_START;
          cnt_next   = CNT_W'(1);
        end
      end
      RX_START: begin
        if (cnt_reg == HALF_M1) begin
          cnt_next = '0;
          bit_next = '0;
          // Line back high at the mid-point: a glitch, not a start bit.
          state_next = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_reg == FULL_M1) begin
          cnt_next   = '0;
          shift_next = {rx_sync, shift_reg[7:1]};
          if (bit_reg == 3'd7) begin
            state_next = RX_STOP;
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_reg == FULL_M1) begin
          cnt_next   = '0;
          state_next = RX_IDLE;
          if (rx_sync) begin
            valid_next = 1'b1;
            data_next  = shift_reg;
          end else begin
            ferr_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = RX_IDLE;
    endcase
  end

  assign data_o      = data_reg;
  assign valid_o     = valid_reg;
  assign frame_err_o = ferr_reg;

endmodule

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
// Receives a program image over UART and writes it into a 32-byte program
// memory while holding the CPU in reset. Frame: SYNC_BYTE, 32 data bytes for
// addresses 0..31, then the mod-256 sum of the data bytes. A good checksum
// releases the CPU; a bad checksum or framing error sets the sticky err_o.
//
// Ports
//   clk_i          clock
//   rst_i          asynchronous active-high reset
//   rx_i           UART receive line (asynchronous)
//   wen_o          program-memory write strobe, one cycle per data byte
//   waddr_o[4:0]   program-memory write address
//   wdata_o[7:0]   program-memory write data
//   cpu_rst_o      CPU reset, high unless the loaded image passed checksum
//   busy_o         frame in progress
//   done_o         last frame passed checksum
//   err_o          sticky checksum/framing error, cleared by a valid sync
// ---------------------------------------------------------------------------
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 16,
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_i,
  output logic              wen_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [7:0]        wdata_o,
  output logic              cpu_rst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ferr;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_rx (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rx_i       (rx_i),
    .data_o     (rx_data),
    .valid_o    (rx_valid),
    .frame_err_o(rx_ferr)
  );

  loader_state_t     state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [7:0]        sum_reg, sum_next;
  logic              err_reg, err_next;
  logic              wen_reg, wen_next;
  logic [ADDR_W-1:0] waddr_reg, waddr_next;
  logic [7:0]        wdata_reg, wdata_next;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      addr_reg  <= '0;
      sum_reg   <= '0;
      err_reg   <= 1'b0;
      wen_reg   <= 1'b0;
      waddr_reg <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      sum_reg   <= sum_next;
      err_reg   <= err_next;
      wen_reg   <= wen_next;
      waddr_reg <= waddr_next;
      wdata_reg <= wdata_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    sum_next   = sum_reg;
    err_next   = err_reg;
    wen_next   = 1'b0;
    waddr_next = waddr_reg;
    wdata_next = wdata_reg;

    if (rx_ferr) begin
      // A badly framed byte poisons the whole frame, whatever state we are in.
      state_next = ST_IDLE;
      err_next   = 1'b1;
    end else if (rx_valid) begin
      unique case (state_reg)
        ST_IDLE, ST_RUN: begin
          if (rx_data == SYNC_BYTE) begin
            state_next = ST_LOAD;
            addr_next  = '0;
            sum_next   = '0;
            err_next   = 1'b0;
          end
        end
        ST_LOAD: begin
          // SYNC_BYTE is ordinary data here; no mid-frame resync.
          wen_next   = 1'b1;
          waddr_next = addr_reg;
          wdata_next = rx_data;
          sum_next   = sum_reg + rx_data;
          addr_next  = addr_reg + 1'b1;
          if (addr_reg == LAST_ADDR) begin
            state_next = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (rx_data == sum_reg) begin
            state_next = ST_RUN;
          end else begin
            state_next = ST_IDLE;
            err_next   = 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign wen_o     = wen_reg;
  assign waddr_o   = waddr_reg;
  assign wdata_o   = wdata_reg;
  assign cpu_rst_o = (state_reg != ST_RUN);
  assign busy_o    = (state_reg == ST_LOAD) || (state_reg == ST_CHECK);
  assign done_o    = (state_reg == ST_RUN);
  assign err_o     = err_reg;

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
// Self-checking bench for prog_loader with CLKS_PER_BIT=4. A byte-level model
// of the frame protocol predicts the memory writes and the status levels.
// ---------------------------------------------------------------------------
module tb_prog_loader;

  localparam int CPB = 4;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       wen;
  logic [4:0] waddr;
  logic [7:0] wdata;
  logic       cpu_rst, busy, done, err;

  always #5 clk = ~clk;

  prog_loader #(
    .CLKS_PER_BIT(CPB),
    .SYNC_BYTE   (SYNC)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .rx_i     (rx),
    .wen_o    (wen),
    .waddr_o  (waddr),
    .wdata_o  (wdata),
    .cpu_rst_o(cpu_rst),
    .busy_o   (busy),
    .done_o   (done),
    .err_o    (err)
  );

  int total = 0;
  int bad   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [4:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        exp_q[$];
  int         m_phase = 0;  // 0 waiting for sync, 1 collecting data, 2 awaiting checksum, 3 running
  int         m_idx   = 0;
  logic [7:0] m_sum   = 8'h00;
  logic       m_err   = 1'b0;
  logic [4:0] hold_a  = 5'd0;
  logic [7:0] hold_d  = 8'd0;
  int         wr_count = 0;

  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    wr_t w;
    if (!stop_ok) begin
      m_err   = 1'b1;
      m_phase = 0;
    end else if (m_phase == 0 || m_phase == 3) begin
      if (b == SYNC) begin
        m_phase = 1;
        m_idx   = 0;
        m_sum   = 8'h00;
        m_err   = 1'b0;
      end
    end else if (m_phase == 1) begin
      w.a = 5'(m_idx);
      w.d = b;
      exp_q.push_back(w);
      m_sum = m_sum + b;
      m_idx++;
      if (m_idx == 32) m_phase = 2;
    end else begin
      if (b == m_sum) m_phase = 3;
      else begin
        m_err   = 1'b1;
        m_phase = 0;
      end
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_phase = 0;
    m_idx   = 0;
    m_sum   = 8'h00;
    m_err   = 1'b0;
    hold_a  = 5'd0;
    hold_d  = 8'd0;
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin
    wr_t w;
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        if (wen) begin
          chk("busy_during_wen", busy, 1);
          if (exp_q.size() == 0) begin
            chk("wen_without_expected_write", wen, 0);
          end else begin
            w = exp_q.pop_front();
            chk("waddr", waddr, w.a);
            chk("wdata", wdata, w.d);
            hold_a = w.a;
            hold_d = w.d;
            wr_count++;
          end
        end else begin
          chk("waddr_hold", waddr, hold_a);
          chk("wdata_hold", wdata, hold_d);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap);
    model_byte(b, stop_ok);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_ok;
    tick(CPB);
    rx = 1'b1;
    tick(gap + (stop_ok ? 0 : CPB));
  endtask

  task automatic check_levels(input string tag);
    tick(10);
    chk({tag, "_pending_writes"}, exp_q.size(), 0);
    chk({tag, "_cpu_rst"}, cpu_rst, (m_phase != 3));
    chk({tag, "_busy"}, busy, (m_phase == 1 || m_phase == 2));
    chk({tag, "_done"}, done, (m_phase == 3));
    chk({tag, "_err"}, err, m_err);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wen"}, wen, 0);
    chk({tag, "_waddr"}, waddr, 0);
    chk({tag, "_wdata"}, wdata, 0);
    chk({tag, "_cpu_rst"}, cpu_rst, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // Sends a full frame; chk_xor alters the checksum, ferr_pct injects bad stop bits.
  task automatic send_frame(input logic [7:0] fr[32], input logic [7:0] chk_xor, input int ferr_pct);
    logic [7:0] s;
    bit ok;
    s = 8'h00;
    for (int i = 0; i < 32; i++) s = s + fr[i];
    send_byte(SYNC, 1'b1, $urandom_range(0, 3));
    for (int i = 0; i < 32; i++) begin
      ok = ($urandom_range(0, 99) >= ferr_pct);
      send_byte(fr[i], ok, $urandom_range(0, 3));
    end
    send_byte(s ^ chk_xor, 1'b1, $urandom_range(0, 3));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] fr[32];
    int base;

    rst = 1'b1;
    tick(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick(1000);
    check_levels("idle_1000");
    chk("idle_cpu_rst_lit", cpu_rst, 1);
    chk("idle_wr_count", wr_count, 0);
    $display("reset and 1000 idle cycles checked");

    // Incrementing frame with correct checksum
    for (int i = 0; i < 32; i++) fr[i] = 8'(i);
    base = wr_count;
    send_frame(fr, 8'h00, 0);
    check_levels("frame_inc");
    chk("model_sum_pin_F0", m_sum, 8'hF0);
    chk("inc_writes", wr_count - base, 32);
    chk("inc_done_lit", done, 1);
    chk("inc_cpu_rst_lit", cpu_rst, 0);
    $display("frame A5/00..1F/F0 sent");

    // Same frame with checksum F1
    base = wr_count;
    send_frame(fr, 8'h01, 0);
    check_levels("frame_badsum");
    chk("badsum_writes", wr_count - base, 32);
    chk("badsum_err_lit", err, 1);
    chk("badsum_cpu_rst_lit", cpu_rst, 1);
    $display("frame A5/00..1F/F1 sent");

    send_frame(fr, 8'h00, 0);
    check_levels("frame_recover");
    chk("recover_err_lit", err, 0);
    chk("recover_done_lit", done, 1);
    $display("recovery frame sent");

    // Reload from RUN
    send_byte(SYNC, 1'b1, 0);
    tick(5);
    chk("reload_cpu_rst_lit", cpu_rst, 1);
    chk("reload_busy_lit", busy, 1);
    for (int i = 0; i < 32; i++) send_byte(8'hFF, 1'b1, 1);
    chk("model_sum_pin_E0", m_sum, 8'hE0);
    send_byte(8'hE0, 1'b1, 0);
    check_levels("frame_ff");
    chk("ff_done_lit", done, 1);
    $display("reload frame of FF sent");

    // Glitch and bad stop bit during LOAD
    send_byte(SYNC, 1'b1, 2);
    for (int i = 0; i < 5; i++) send_byte(8'(8'h30 + i), 1'b1, 1);
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    tick(12);
    check_levels("glitch");
    chk("glitch_err_lit", err, 0);
    send_byte(8'h5A, 1'b0, 2);
    check_levels("bad_stop");
    chk("bad_stop_err_lit", err, 1);
    chk("bad_stop_busy_lit", busy, 0);
    $display("glitch and bad stop bit sent");

    // Reset after 10 data bytes
    base = wr_count;
    send_byte(SYNC, 1'b1, 1);
    for (int i = 0; i < 10; i++) send_byte(8'($urandom_range(0, 255)), 1'b1, 1);
    tick(8);
    chk("pre_reset_writes", wr_count - base, 10);
    rst = 1'b1;
    model_reset();
    #1;
    check_reset_outputs("midframe_reset");
    tick(3);
    rst = 1'b0;
    base = wr_count;
    tick(100);
    chk("post_reset_writes", wr_count - base, 0);
    check_levels("post_reset");
    $display("mid-frame reset applied");

    // Randomized frames
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 32; i++) fr[i] = 8'($urandom_range(0, 255));
      send_frame(fr, ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                 ($urandom_range(0, 2) == 0) ? 3 : 0);
      check_levels("random");
      $display("random frame %0d: phase=%0d err=%0d", f, m_phase, m_err);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per UART bit period (minimum 4).
REQ-002 Parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-003 Port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port rx_i, input, 1 bit: asynchronous UART receive line, 8N1, LSB first, idle high.
REQ-006 Port wen_o, output, 1 bit: program-memory write strobe, one cycle per data byte.
REQ-007 Port waddr_o, output, 5 bits: program-memory write address, the CPU instruction address space 0..31.
REQ-008 Port wdata_o, output, 8 bits: program-memory write data.
REQ-009 Port cpu_rst_o, output, 1 bit: hold the CPU in reset while high.
REQ-010 Port busy_o, output, 1 bit: high while a frame is in progress (LOAD or CHECK).
REQ-011 Port done_o, output, 1 bit: high while the last frame passed checksum (RUN).
REQ-012 Port err_o, output, 1 bit: sticky; set by a checksum or framing error, cleared by the next valid sync byte.

Function
REQ-013 rx_i SHALL pass through a 2-flop synchronizer before any use; that adds 2 cycles of latency.
REQ-014 The receiver SHALL detect a start bit on a synchronized high-to-low edge and re-sample at CLKS_PER_BIT/2; if the line is high again it SHALL return to idle (glitch reject) without flagging an error.
REQ-015 Data bits SHALL be sampled at each full bit period after the start mid-point; the stop bit is sampled one bit period after bit 7.
REQ-016 A stop bit sampled low SHALL discard the byte, set err_o, and return the FSM to IDLE; cpu_rst_o stays high.
REQ-017 A byte is valid in the cycle after its stop-bit sample; the receiver SHALL be ready for a new start edge in that same cycle.
REQ-018 Frame format: SYNC_BYTE, then 32 data bytes for addresses 0..31 in order, then one checksum byte equal to the 8-bit sum (mod 256) of the 32 data bytes.
REQ-019 FSM states: IDLE, LOAD, CHECK, RUN.
REQ-020 IDLE: cpu_rst_o=1. A valid byte equal to SYNC_BYTE moves to LOAD, clears the address counter and checksum, and clears err_o. Any other byte is ignored.
REQ-021 LOAD: each valid byte SHALL produce wen_o=1 for exactly one cycle, with waddr_o equal to the counter, wdata_o equal to the byte, and the sum accumulated. The counter increments after each write.
REQ-022 After the write to address 31 the FSM SHALL enter CHECK; the 5-bit counter wraps to 0 and is never written past 31.
REQ-023 CHECK: the next valid byte is compared with the sum. On a match, go to RUN. On a mismatch, set err_o and go to IDLE.
REQ-024 RUN: cpu_rst_o=0 and done_o=1 from the cycle after the checksum byte is valid.
REQ-025 In RUN, a valid byte equal to SYNC_BYTE SHALL assert cpu_rst_o in the next cycle and enter LOAD as in REQ-020. Other bytes are ignored.
REQ-026 In LOAD, a SYNC_BYTE value is ordinary data; there is no re-sync mid-frame.
REQ-027 wen_o SHALL never be high outside LOAD; waddr_o and wdata_o hold their last value when wen_o=0.
REQ-028 No timeout: a stalled frame keeps busy_o=1 and cpu_rst_o=1 indefinitely.

Reset
REQ-029 While rst_i=1: FSM=IDLE, receiver idle, synchronizer flops=1, counter=0, sum=0.
REQ-030 While rst_i=1 the outputs SHALL be wen_o=0, waddr_o=0, wdata_o=0, cpu_rst_o=1, busy_o=0, done_o=0, err_o=0.
REQ-031 Reset mid-frame SHALL abort the frame without completing any pending write.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding, SYNC_BYTE default, frame length (32), and address width (5).
REQ-033 The UART byte receiver SHALL be a sub-module, uart_rx (ports: clk_i, rst_i, rx_i, data_o[7:0], valid_o, frame_err_o). The framing FSM stays in prog_loader.

Verification (CLKS_PER_BIT=4)
REQ-034 Reset -> cpu_rst_o=1, wen_o=0, done_o=0, err_o=0; rx_i held high for 1000 cycles -> no change.
REQ-035 Send A5, data bytes 00..1F, checksum F0 -> 32 strobes at addr 0..31 with data = addr, then cpu_rst_o=0 and done_o=1.
REQ-036 Same frame with checksum F1 -> 32 writes, then err_o=1, cpu_rst_o=1, FSM in IDLE; a following good frame clears err_o and sets done_o.
REQ-037 In RUN, send A5 -> cpu_rst_o=1 the next cycle, busy_o=1; reload a frame of all 0xFF with checksum E0 -> RUN.
REQ-038 A 1-cycle low glitch on rx_i, and separately a byte with its stop bit forced low during LOAD -> the glitch is ignored; the bad stop bit gives err_o=1 and IDLE.
REQ-039 Assert rst_i after 10 data bytes -> outputs match REQ-030 immediately, and no further wen_o pulse occurs.
